// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic {
    StFetch = 1'b0,
    StExec  = 1'b1
  } fetch_state_e;

  // Width of a phase index for the given phase count (at least one bit).
  function automatic int unsigned phase_w(input int unsigned nphase);
    return (nphase < 2) ? 1 : $clog2(nphase);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Phase index within an instruction: restarts at 1 on fetch completion,
// advances while execution is not stalled, and wraps to 0 after the last phase.
module phase_counter
  import fetch_pkg::*;
#(
  parameter int unsigned NPHASE = 2
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic                          start,
  input  logic                          advance,
  output logic [phase_w(NPHASE)-1:0]    phase,
  output logic                          last
);

  localparam int unsigned PW = phase_w(NPHASE);
  localparam logic [PW-1:0] LastPhase = PW'(NPHASE - 1);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      phase <= '0;
    end else if (start) begin
      phase <= PW'(1);
    end else if (advance) begin
      phase <= last ? '0 : phase + PW'(1);
    end
  end

  assign last = (phase == LastPhase);

endmodule

// File: rtl/fetch_sequencer.sv
// Microcoded instruction fetch sequencer: one fetch phase that waits for memory,
// then NPHASE-1 stallable execute phases, with an optional branch on the last one.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       WORD_W    = 8,
  parameter int unsigned       OPC_W     = 4,
  parameter int unsigned       NPHASE    = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                        clk,
  input  logic                        Rst,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [WORD_W-1:0]           mem_data,
  input  logic                        mem_valid,
  input  logic                        load_pc,
  input  logic [ADDR_W-1:0]           newaddr,
  input  logic                        stall,
  output logic [ADDR_W-1:0]           pc,
  output logic [OPC_W-1:0]            instr,
  output logic [WORD_W-OPC_W-1:0]     operand,
  output logic [phase_w(NPHASE)-1:0]  phase,
  output logic                        exec_en,
  output logic                        instr_valid
);

  fetch_state_e state;
  logic         fetch_done;
  logic         advance;
  logic         last;

  assign fetch_done = (state == StFetch) && mem_valid;
  assign advance    = (state == StExec) && !stall;

  phase_counter #(
    .NPHASE (NPHASE)
  ) u_phase_counter (
    .clk     (clk),
    .Rst     (Rst),
    .start   (fetch_done),
    .advance (advance),
    .phase   (phase),
    .last    (last)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state       <= StFetch;
      pc          <= RESET_VEC;
      instr       <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        StFetch: begin
          if (mem_valid) begin
            instr       <= mem_data[WORD_W-1 -: OPC_W];
            operand     <= mem_data[WORD_W-OPC_W-1:0];
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            state       <= StExec;
          end
        end
        StExec: begin
          // Branches are only honoured on the final unstalled execute phase.
          if (advance && last) begin
            state <= StFetch;
            if (load_pc) pc <= newaddr;
          end
        end
      endcase
    end
  end

  // Request is masked by reset so memory sees no fetch while the core is held.
  assign mem_req  = (state == StFetch) && !Rst;
  assign mem_addr = pc;
  assign exec_en  = advance;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a small-address NPHASE=3 instance checked
// every cycle against a behavioural model, plus a default instance with memory always ready.
module tb_fetch_sequencer;

  localparam int NP = 3;

  logic       clk;
  logic       Rst;
  logic       mem_valid;
  logic [7:0] mem_data;
  logic       load_pc;
  logic [3:0] newaddr;
  logic       stall;

  logic       d0_mem_req, d0_exec_en, d0_valid;
  logic [3:0] d0_addr, d0_pc, d0_instr, d0_operand;
  logic [1:0] d0_phase;

  logic        d1_mem_req, d1_exec_en, d1_valid;
  logic [11:0] d1_addr, d1_pc;
  logic [3:0]  d1_instr, d1_operand;
  logic [0:0]  d1_phase;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 means waiting for the instruction word.
  int         m_phase;
  int         m_pc;
  logic [3:0] m_instr, m_oper;
  logic       m_valid;

  fetch_sequencer #(
    .ADDR_W    (4),
    .WORD_W    (8),
    .OPC_W     (4),
    .NPHASE    (NP),
    .RESET_VEC (4'hF)
  ) u_dut0 (
    .clk         (clk),
    .Rst         (Rst),
    .mem_req     (d0_mem_req),
    .mem_addr    (d0_addr),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .load_pc     (load_pc),
    .newaddr     (newaddr),
    .stall       (stall),
    .pc          (d0_pc),
    .instr       (d0_instr),
    .operand     (d0_operand),
    .phase       (d0_phase),
    .exec_en     (d0_exec_en),
    .instr_valid (d0_valid)
  );

  fetch_sequencer u_dut1 (
    .clk         (clk),
    .Rst         (Rst),
    .mem_req     (d1_mem_req),
    .mem_addr    (d1_addr),
    .mem_data    (8'h3C),
    .mem_valid   (1'b1),
    .load_pc     (1'b0),
    .newaddr     (12'h000),
    .stall       (1'b0),
    .pc          (d1_pc),
    .instr       (d1_instr),
    .operand     (d1_operand),
    .phase       (d1_phase),
    .exec_en     (d1_exec_en),
    .instr_valid (d1_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 15;
    m_instr = '0;
    m_oper  = '0;
    m_valid = 1'b0;
  endtask

  task automatic model_update();
    if (Rst) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (mem_valid) begin
        m_instr = mem_data[7:4];
        m_oper  = mem_data[3:0];
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % 16;
        m_phase = 1;
      end
    end else if (!stall) begin
      if (m_phase == NP - 1) begin
        m_phase = 0;
        if (load_pc) m_pc = int'(newaddr);
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic compare_model();
    chk("mem_req", 32'(d0_mem_req), 32'(!Rst && m_phase == 0));
    chk("mem_addr", 32'(d0_addr), 32'(m_pc));
    chk("pc", 32'(d0_pc), 32'(m_pc));
    chk("phase", 32'(d0_phase), 32'(m_phase));
    chk("exec_en", 32'(d0_exec_en), 32'(!Rst && m_phase != 0 && !stall));
    chk("instr", 32'(d0_instr), 32'(m_instr));
    chk("operand", 32'(d0_operand), 32'(m_oper));
    chk("instr_valid", 32'(d0_valid), 32'(m_valid));
  endtask

  // Drive one cycle's inputs on the falling edge, check, then advance the model
  // on the rising edge; returns shortly after that edge.
  task automatic step(input logic r, input logic mv, input logic [7:0] md,
                      input logic lp, input logic [3:0] na, input logic st);
    @(negedge clk);
    Rst       = r;
    mem_valid = mv;
    mem_data  = md;
    load_pc   = lp;
    newaddr   = na;
    stall     = st;
    #1;
    if (r) model_reset();
    compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    Rst       = 1'b1;
    mem_valid = 1'b0;
    mem_data  = '0;
    load_pc   = 1'b0;
    newaddr   = '0;
    stall     = 1'b0;
    model_reset();

    // Reset state.
    step(1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    chk("rst_pc", 32'(d0_pc), 32'hF);
    chk("rst_mem_req", 32'(d0_mem_req), 32'h0);
    chk("rst_d1_pc", 32'(d1_pc), 32'h0);
    chk("rst_d1_valid", 32'(d1_valid), 32'h0);

    // Memory not ready for three cycles; the default instance fetches every other cycle.
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    chk("wait_req", 32'(d0_mem_req), 32'h1);
    chk("wait_addr", 32'(d0_addr), 32'hF);
    chk("d1_ph_a", 32'(d1_phase), 32'h1);
    chk("d1_pc_a", 32'(d1_pc), 32'h1);
    chk("d1_exec_a", 32'(d1_exec_en), 32'h1);
    chk("d1_instr", 32'({d1_instr, d1_operand}), 32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    chk("d1_ph_b", 32'(d1_phase), 32'h0);
    chk("d1_pc_b", 32'(d1_pc), 32'h1);
    chk("d1_exec_b", 32'(d1_exec_en), 32'h0);
    chk("d1_req_b", 32'(d1_mem_req), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    chk("d1_ph_c", 32'(d1_phase), 32'h1);
    chk("d1_pc_c", 32'(d1_pc), 32'h2);
    chk("wait_phase", 32'(d0_phase), 32'h0);

    // Fetch wraps pc from 0xF to 0.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 4'h0, 1'b0);
    chk("wrap_pc", 32'(d0_pc), 32'h0);
    chk("fetch_instr", 32'(d0_instr), 32'hA);
    chk("fetch_oper", 32'(d0_operand), 32'h5);
    chk("fetch_phase", 32'(d0_phase), 32'h1);

    // Stall holds phase 1; branch strobes here are ignored.
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'h3, 1'b1);
    chk("stall_phase", 32'(d0_phase), 32'h1);
    chk("stall_exec", 32'(d0_exec_en), 32'h0);
    step(1'b0, 1'b1, 8'h11, 1'b1, 4'h3, 1'b1);
    chk("stall_phase2", 32'(d0_phase), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 4'h3, 1'b0);
    chk("early_load_pc", 32'(d0_pc), 32'h0);
    chk("phase_two", 32'(d0_phase), 32'h2);

    // Branch on the last phase.
    step(1'b0, 1'b1, 8'hFF, 1'b1, 4'h7, 1'b0);
    chk("branch_addr", 32'(d0_addr), 32'h7);
    chk("branch_phase", 32'(d0_phase), 32'h0);
    chk("branch_instr", 32'(d0_instr), 32'hA);

    // Randomized run, including asynchronous resets mid-instruction.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
